mem_access: RTL and testbench
=============================

MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, synchronous, active-high.
REQ-003 rdy  input  1  global ready; low = all state frozen, no new memory requests.
REQ-004 stall_hold  input  1  high = later stage holds this stage; current op must not retire or re-issue.
REQ-005 mac_pc, mac_mem_addr, mac_reg2  input  32 each  pc, effective address, store data from EX/MEM register.
REQ-006 mac_wd  input  5  destination register.
REQ-007 mac_wreg  input  1  register write enable.
REQ-008 mac_wdata  input  32  ALU result.
REQ-009 mac_aluop  input  8  op code; classes LB, LH, LW, LBU, LHU, SB, SH, SW, anything else = non-memory.
REQ-010 mreq_valid, mreq_we  output  1 each  byte request valid, write enable.
REQ-011 mreq_addr  output  32  byte address.
REQ-012 mreq_wdata  output  8  store byte.
REQ-013 mreq_ready  input  1  controller accepts request this cycle when valid and ready.
REQ-014 mresp_valid, mresp_data  input  1, 8  read byte return, in order, latency >= 1 cycle.
REQ-015 stallreq  output  1  request upstream stall.
REQ-016 wb_wd 5, wb_wreg 1, wb_wdata 32, wb_pc 32  outputs  writeback fields.
REQ-017 mem_misalign  output  1  misaligned access flag (see REQ-036).

Function
REQ-018 Non-memory op in IDLE: wb_* = mac_* combinationally; stallreq = 0; no requests.
REQ-019 States: IDLE, ISSUE, WAIT, DONE.
REQ-020 IDLE + memory op + rdy -> ISSUE; stallreq asserted combinationally in that same cycle.
REQ-021 Byte count N: 1 for B/BU, 2 for H/HU, 4 for W.
REQ-022 ISSUE: byte k (k = 0..N-1) issued at mac_mem_addr + k (32-bit wrap), little-endian; k advances only on valid and ready.
REQ-023 Store byte k = mac_reg2[8k+7:8k]; mreq_we = 1.
REQ-024 Store: last byte accepted -> DONE; no response expected.
REQ-025 Load: requests may be issued while earlier responses outstanding; responses fill byte (received count) of an internal buffer.
REQ-026 Load: all N bytes issued but not all received -> WAIT; Nth response -> DONE.
REQ-027 Load result: LB/LH sign-extend, LBU/LHU zero-extend, LW raw.
REQ-028 DONE: stallreq = 0; wb_wd/wb_wreg/wb_pc from mac_*; wb_wdata = load result (load) or mac_wdata (store); wb_wreg forced 0 for stores.
REQ-029 DONE with stall_hold = 1: remain in DONE, outputs held, no re-issue.
REQ-030 DONE with stall_hold = 0: -> IDLE next cycle.
REQ-031 rdy = 0: state, counters and buffer frozen, mreq_valid = 0; mresp_valid ignored.
REQ-032 mresp_valid outside ISSUE/WAIT of a load: ignored.
REQ-033 mreq_valid never asserted in IDLE, WAIT or DONE.

Reset
REQ-034 rst: state IDLE; counters and buffer 0; mreq_valid 0; mreq_we 0; mreq_addr 0; mreq_wdata 0; stallreq 0; mem_misalign 0; wb_* driven as REQ-018.
REQ-035 rst mid-transaction aborts immediately; outstanding responses after reset are ignored per REQ-032.

Configuration
REQ-036 MEM_MISALIGN_CHK_EN defined: H/HU with addr[0] != 0, or W with addr[1:0] != 0 -> no requests, direct to DONE, mem_misalign = 1 in DONE, wb_wreg = 0; undefined: misaligned accesses run byte-serially per REQ-022 and mem_misalign is tied 0.

Verification
REQ-037 LW addr 0x100, mreq_ready = 1, responses 0x78, 0x56, 0x34, 0x12 at latency 2 -> four requests 0x100..0x103, DONE wb_wdata = 0x12345678, stallreq high until DONE.
REQ-038 SH addr 0x202, reg2 = 0xAABBCCDD, mreq_ready toggling 1/0 -> writes 0xDD@0x202, 0xCC@0x203 only, wb_wreg = 0.
REQ-039 LB response 0x80 -> wb_wdata = 0xFFFFFF80; LBU -> 0x00000080.
REQ-040 DONE with stall_hold = 1 for 3 cycles -> no new mreq_valid, outputs stable; IDLE after release.
REQ-041 LW addr 0x301: with MEM_MISALIGN_CHK_EN -> no requests, mem_misalign = 1; without it -> 4 requests 0x301..0x304.
REQ-042 rst asserted after 2 of 4 LW bytes issued -> IDLE, stallreq = 0, late responses ignored, next ADD op passes through.

Source files
------------

// File: rtl/mem_access_if.sv
// Byte-wide memory request/response bus between the memory-access stage and the memory controller.
// Handshake: a request transfers on a rising edge where mreq_valid && mreq_ready; while mreq_valid is
// high the request fields are held stable until that edge. Read bytes come back on mresp_valid, one per
// cycle, in request order, at least one cycle after acceptance; there is no back-pressure on responses.
interface mem_access_if;
  logic        mreq_valid;
  logic        mreq_we;
  logic [31:0] mreq_addr;
  logic [7:0]  mreq_wdata;
  logic        mreq_ready;
  logic        mresp_valid;
  logic [7:0]  mresp_data;

  modport master (
    output mreq_valid, mreq_we, mreq_addr, mreq_wdata,
    input  mreq_ready, mresp_valid, mresp_data
  );

  modport slave (
    input  mreq_valid, mreq_we, mreq_addr, mreq_wdata,
    output mreq_ready, mresp_valid, mresp_data
  );
endinterface

// File: rtl/mem_access.sv
// Memory-access stage: splits LB/LH/LW/LBU/LHU/SB/SH/SW into little-endian byte requests.
// Define MEM_MISALIGN_CHK_EN to trap misaligned half/word accesses instead of running them byte-serially.
module mem_access (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                stall_hold,
  input  logic [31:0]         mac_pc,
  input  logic [31:0]         mac_mem_addr,
  input  logic [31:0]         mac_reg2,
  input  logic [4:0]          mac_wd,
  input  logic                mac_wreg,
  input  logic [31:0]         mac_wdata,
  input  logic [7:0]          mac_aluop,
  mem_access_if.master        mem,
  output logic                stallreq,
  output logic [4:0]          wb_wd,
  output logic                wb_wreg,
  output logic [31:0]         wb_wdata,
  output logic [31:0]         wb_pc,
  output logic                mem_misalign,
  output logic [1:0]          dbg_state_o
);

  localparam logic [7:0] OP_LB  = 8'hE0;
  localparam logic [7:0] OP_LH  = 8'hE1;
  localparam logic [7:0] OP_LW  = 8'hE3;
  localparam logic [7:0] OP_LBU = 8'hE4;
  localparam logic [7:0] OP_LHU = 8'hE5;
  localparam logic [7:0] OP_SB  = 8'hE8;
  localparam logic [7:0] OP_SH  = 8'hE9;
  localparam logic [7:0] OP_SW  = 8'hEB;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  issue_cnt_q, issue_cnt_d;
  logic [2:0]  recv_cnt_q, recv_cnt_d;
  logic [31:0] buf_q, buf_d;
  logic        misalign_q, misalign_d;

  logic        is_byte, is_half, is_word;
  logic        is_load, is_store, is_mem;
  logic        misalign_now;
  logic [2:0]  n_bytes;
  logic        req_valid;
  logic        req_fire;
  logic [31:0] load_result;

  always_comb begin
    is_byte  = mac_aluop inside {OP_LB, OP_LBU, OP_SB};
    is_half  = mac_aluop inside {OP_LH, OP_LHU, OP_SH};
    is_word  = mac_aluop inside {OP_LW, OP_SW};
    is_load  = mac_aluop inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
    is_store = mac_aluop inside {OP_SB, OP_SH, OP_SW};
    is_mem   = is_load || is_store;
    n_bytes  = is_word ? 3'd4 : (is_half ? 3'd2 : 3'd1);
  end

`ifdef MEM_MISALIGN_CHK_EN
  assign misalign_now = (is_half && mac_mem_addr[0]) ||
                        (is_word && (mac_mem_addr[1:0] != 2'b00));
`else
  assign misalign_now = 1'b0;
`endif

  // rdy low freezes every register, including anything a response would have written.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      issue_cnt_q <= 3'd0;
      recv_cnt_q  <= 3'd0;
      buf_q       <= 32'd0;
      misalign_q  <= 1'b0;
    end else if (rdy) begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      recv_cnt_q  <= recv_cnt_d;
      buf_q       <= buf_d;
      misalign_q  <= misalign_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    issue_cnt_d = issue_cnt_q;
    recv_cnt_d  = recv_cnt_q;
    buf_d       = buf_q;
    misalign_d  = misalign_q;
    req_valid   = 1'b0;
    req_fire    = 1'b0;

    // Responses land in arrival order; they may overlap with later requests still being issued.
    if ((state_q == S_ISSUE || state_q == S_WAIT) && is_load && mem.mresp_valid) begin
      buf_d[{recv_cnt_q[1:0], 3'b000} +: 8] = mem.mresp_data;
      recv_cnt_d = recv_cnt_q + 3'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (is_mem) begin
          issue_cnt_d = 3'd0;
          recv_cnt_d  = 3'd0;
          buf_d       = 32'd0;
          if (misalign_now) begin
            state_d    = S_DONE;
            misalign_d = 1'b1;
          end else begin
            state_d    = S_ISSUE;
            misalign_d = 1'b0;
          end
        end
      end
      S_ISSUE: begin
        req_valid = rdy && !rst;
        req_fire  = req_valid && mem.mreq_ready;
        if (req_fire) issue_cnt_d = issue_cnt_q + 3'd1;
        if (issue_cnt_d == n_bytes) begin
          state_d = (is_store || recv_cnt_d == n_bytes) ? S_DONE : S_WAIT;
        end
      end
      S_WAIT: begin
        if (recv_cnt_d == n_bytes) state_d = S_DONE;
      end
      S_DONE: begin
        if (!stall_hold) begin
          state_d    = S_IDLE;
          misalign_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign mem.mreq_valid = req_valid;
  assign mem.mreq_we    = req_valid && is_store;
  assign mem.mreq_addr  = req_valid ? (mac_mem_addr + {29'd0, issue_cnt_q}) : 32'd0;
  assign mem.mreq_wdata = (req_valid && is_store) ? mac_reg2[{issue_cnt_q[1:0], 3'b000} +: 8] : 8'd0;

  always_comb begin
    case (mac_aluop)
      OP_LB:   load_result = {{24{buf_q[7]}}, buf_q[7:0]};
      OP_LBU:  load_result = {24'd0, buf_q[7:0]};
      OP_LH:   load_result = {{16{buf_q[15]}}, buf_q[15:0]};
      OP_LHU:  load_result = {16'd0, buf_q[15:0]};
      default: load_result = buf_q;
    endcase
  end

  // Register write is suppressed while the op is in flight so a held pipeline never commits early.
  always_comb begin
    stallreq     = 1'b0;
    wb_wd        = mac_wd;
    wb_pc        = mac_pc;
    wb_wdata     = mac_wdata;
    wb_wreg      = mac_wreg;
    mem_misalign = 1'b0;
    if (!rst) begin
      case (state_q)
        S_IDLE: begin
          if (is_mem) begin
            stallreq = 1'b1;
            wb_wreg  = 1'b0;
          end
        end
        S_ISSUE, S_WAIT: begin
          stallreq = 1'b1;
          wb_wreg  = 1'b0;
        end
        S_DONE: begin
`ifdef MEM_MISALIGN_CHK_EN
          mem_misalign = misalign_q;
`endif
          wb_wreg = mac_wreg && is_load && !misalign_q;
          if (is_load && !misalign_q) wb_wdata = load_result;
        end
        default: ;
      endcase
    end
  end

  assign dbg_state_o = state_q;

  a_req_only_in_issue: assert property (@(posedge clk) disable iff (rst)
    mem.mreq_valid |-> state_q == S_ISSUE);
  a_issue_bounded: assert property (@(posedge clk) disable iff (rst)
    issue_cnt_q <= 3'd4 && recv_cnt_q <= 3'd4);

  logic unused_ok;
  assign unused_ok = is_byte;

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: vector table of complete memory ops plus hand sequences for
// stall_hold, rdy freeze and mid-transaction reset. Memory responses come back at latency 2.
module tb_mem_access;
  localparam logic [7:0] OP_LB  = 8'hE0;
  localparam logic [7:0] OP_LH  = 8'hE1;
  localparam logic [7:0] OP_LW  = 8'hE3;
  localparam logic [7:0] OP_LBU = 8'hE4;
  localparam logic [7:0] OP_LHU = 8'hE5;
  localparam logic [7:0] OP_SB  = 8'hE8;
  localparam logic [7:0] OP_SH  = 8'hE9;
  localparam logic [7:0] OP_SW  = 8'hEB;
  localparam logic [7:0] OP_ADD = 8'h20;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd3;
  localparam int NV = 11;

  typedef struct {
    logic [7:0]  op;
    logic [31:0] addr;
    logic [31:0] reg2;
    logic [31:0] mem_w;
    bit          toggle;
    int          n;
    logic [31:0] exp_wdata;
    logic        exp_wreg;
    logic        exp_mis;
  } vec_t;

  typedef struct {
    int         due;
    logic [7:0] data;
  } resp_t;

  logic        clk = 1'b0;
  logic        rst, rdy, stall_hold;
  logic [31:0] mac_pc, mac_mem_addr, mac_reg2, mac_wdata;
  logic [4:0]  mac_wd;
  logic        mac_wreg;
  logic [7:0]  mac_aluop;
  logic        stallreq;
  logic [4:0]  wb_wd;
  logic        wb_wreg;
  logic [31:0] wb_wdata, wb_pc;
  logic        mem_misalign;
  logic [1:0]  dbg_state;

  mem_access_if bus();

  mem_access dut (
    .clk          (clk),
    .rst          (rst),
    .rdy          (rdy),
    .stall_hold   (stall_hold),
    .mac_pc       (mac_pc),
    .mac_mem_addr (mac_mem_addr),
    .mac_reg2     (mac_reg2),
    .mac_wd       (mac_wd),
    .mac_wreg     (mac_wreg),
    .mac_wdata    (mac_wdata),
    .mac_aluop    (mac_aluop),
    .mem          (bus.master),
    .stallreq     (stallreq),
    .wb_wd        (wb_wd),
    .wb_wreg      (wb_wreg),
    .wb_wdata     (wb_wdata),
    .wb_pc        (wb_pc),
    .mem_misalign (mem_misalign),
    .dbg_state_o  (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  logic [47:0] exp_q[$];
  resp_t       resp_q[$];
  logic [7:0]  mem_a [logic [31:0]];
  int          cyc = 0;
  int          n_vec = 0;
  int          n_fail = 0;
  logic [47:0] mon_got;
  resp_t       mon_r;
  vec_t        vecs [NV];

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // scoreboard: every accepted request must match the head of exp_q
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (bus.mreq_valid && bus.mreq_ready) begin
      mon_got = {7'd0, bus.mreq_we, bus.mreq_addr, bus.mreq_wdata};
      if (exp_q.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL unexpected_req: got 0x%0h expected no request", mon_got);
      end else begin
        check("req", mon_got, exp_q.pop_front());
      end
      if (!bus.mreq_we) begin
        mon_r.due  = cyc + 1;
        mon_r.data = mem_a.exists(bus.mreq_addr) ? mem_a[bus.mreq_addr] : 8'h00;
        resp_q.push_back(mon_r);
      end
    end
  end

  // response driver
  initial begin
    bus.mresp_valid = 1'b0;
    bus.mresp_data  = 8'h00;
    forever begin
      @(negedge clk);
      if (resp_q.size() > 0 && resp_q[0].due <= cyc) begin
        bus.mresp_valid = 1'b1;
        bus.mresp_data  = resp_q[0].data;
        void'(resp_q.pop_front());
      end else begin
        bus.mresp_valid = 1'b0;
        bus.mresp_data  = 8'h00;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic set_mem(input logic [31:0] addr, input logic [31:0] w);
    for (int i = 0; i < 4; i++) mem_a[addr + 32'(i)] = w[8*i +: 8];
  endtask

  task automatic start_op(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] reg2, input int n);
    logic st;
    st = op inside {OP_SB, OP_SH, OP_SW};
    for (int k = 0; k < n; k++)
      exp_q.push_back({7'd0, st, addr + 32'(k), st ? reg2[8*k +: 8] : 8'h00});
    @(negedge clk);
    mac_aluop    = op;
    mac_mem_addr = addr;
    mac_reg2     = reg2;
    #1;
    check("stall_on_start", stallreq, 1'b1);
  endtask

  task automatic wait_done(input string tag, input bit toggle, output bit stall_ok);
    bit done;
    done = 1'b0;
    stall_ok = 1'b1;
    for (int c = 0; c < 80 && !done; c++) begin
      @(negedge clk);
      if (dbg_state == ST_DONE) done = 1'b1;
      else begin
        if (!stallreq) stall_ok = 1'b0;
        if (toggle) bus.mreq_ready = ~bus.mreq_ready;
      end
    end
    check({tag, "_reach_done"}, done, 1'b1);
  endtask

  task automatic release_op();
    @(posedge clk);
    #1;
    mac_aluop = OP_ADD;
    bus.mreq_ready = 1'b1;
    @(negedge clk);
    check("idle_after_done", dbg_state, ST_IDLE);
    exp_q.delete();
  endtask

  initial begin
    bit stall_ok;
    string t;

    //                op      addr          reg2          mem_w         tgl n  exp_wdata     wreg  mis
    vecs[0]  = '{OP_LW,  32'h0000_0100, 32'h0,        32'h1234_5678, 1'b0, 4, 32'h1234_5678, 1'b1, 1'b0};
    vecs[1]  = '{OP_SH,  32'h0000_0202, 32'hAABB_CCDD, 32'h0,        1'b1, 2, 32'hCAFE_0001, 1'b0, 1'b0};
    vecs[2]  = '{OP_LB,  32'h0000_0400, 32'h0,        32'h0000_0080, 1'b0, 1, 32'hFFFF_FF80, 1'b1, 1'b0};
    vecs[3]  = '{OP_LBU, 32'h0000_0400, 32'h0,        32'h0000_0080, 1'b0, 1, 32'h0000_0080, 1'b1, 1'b0};
    vecs[4]  = '{OP_LH,  32'h0000_0502, 32'h0,        32'h0000_9234, 1'b0, 2, 32'hFFFF_9234, 1'b1, 1'b0};
    vecs[5]  = '{OP_LHU, 32'h0000_0502, 32'h0,        32'h0000_9234, 1'b0, 2, 32'h0000_9234, 1'b1, 1'b0};
    vecs[6]  = '{OP_SB,  32'h0000_0600, 32'h1122_3344, 32'h0,        1'b1, 1, 32'hCAFE_0001, 1'b0, 1'b0};
    vecs[7]  = '{OP_SW,  32'h0000_0700, 32'hDEAD_BEEF, 32'h0,        1'b0, 4, 32'hCAFE_0001, 1'b0, 1'b0};
    vecs[8]  = '{OP_LW,  32'hFFFF_FFFE, 32'h0,        32'h0403_0201, 1'b0, 4, 32'h0403_0201, 1'b1, 1'b0};
`ifdef MEM_MISALIGN_CHK_EN
    vecs[9]  = '{OP_LW,  32'h0000_0301, 32'h0,        32'hA1B2_C3D4, 1'b0, 0, 32'hCAFE_0001, 1'b0, 1'b1};
`else
    vecs[9]  = '{OP_LW,  32'h0000_0301, 32'h0,        32'hA1B2_C3D4, 1'b0, 4, 32'hA1B2_C3D4, 1'b1, 1'b0};
`endif
    vecs[10] = '{OP_LW,  32'h0000_0120, 32'h0,        32'h89AB_CDEF, 1'b1, 4, 32'h89AB_CDEF, 1'b1, 1'b0};

    rst = 1'b1; rdy = 1'b1; stall_hold = 1'b0;
    mac_aluop = OP_ADD; mac_pc = 32'h0040_0000; mac_mem_addr = 32'h0001_2345;
    mac_reg2 = 32'h0000_FFFF; mac_wd = 5'd9; mac_wreg = 1'b1; mac_wdata = 32'hCAFE_0001;
    bus.mreq_ready = 1'b1;
    repeat (3) @(negedge clk);

    check("rst_state", dbg_state, ST_IDLE);
    check("rst_mreq_valid", bus.mreq_valid, 1'b0);
    check("rst_mreq_we", bus.mreq_we, 1'b0);
    check("rst_mreq_addr", bus.mreq_addr, 32'h0);
    check("rst_mreq_wdata", bus.mreq_wdata, 8'h0);
    check("rst_stallreq", stallreq, 1'b0);
    check("rst_misalign", mem_misalign, 1'b0);
    check("rst_wb_wdata", wb_wdata, 32'hCAFE_0001);
    check("rst_wb_pc", wb_pc, 32'h0040_0000);

    rst = 1'b0;
    @(negedge clk);
    mac_wdata = 32'h1357_2468; mac_wd = 5'd17; mac_wreg = 1'b0;
    #1;
    check("pass_wdata", wb_wdata, 32'h1357_2468);
    check("pass_wd", wb_wd, 5'd17);
    check("pass_wreg", wb_wreg, 1'b0);
    check("pass_stallreq", stallreq, 1'b0);
    @(negedge clk);
    check("pass_state", dbg_state, ST_IDLE);
    check("pass_no_req", bus.mreq_valid, 1'b0);
    mac_wdata = 32'hCAFE_0001; mac_wd = 5'd9; mac_wreg = 1'b1;

    for (int i = 0; i < NV; i++) begin
      set_mem(vecs[i].addr, vecs[i].mem_w);
      start_op(vecs[i].op, vecs[i].addr, vecs[i].reg2, vecs[i].n);
      t = $sformatf("v%0d", i);
      wait_done(t, vecs[i].toggle, stall_ok);
      check({t, "_stall_until_done"}, stall_ok, 1'b1);
      check({t, "_done_stallreq"}, stallreq, 1'b0);
      check({t, "_wb_wdata"}, wb_wdata, vecs[i].exp_wdata);
      check({t, "_wb_wreg"}, wb_wreg, vecs[i].exp_wreg);
      check({t, "_wb_wd"}, wb_wd, 5'd9);
      check({t, "_misalign"}, mem_misalign, vecs[i].exp_mis);
      check({t, "_reqs_missing"}, exp_q.size(), 0);
      release_op();
    end

    // DONE held by a later stage
    stall_hold = 1'b1;
    start_op(OP_LW, 32'h0000_0100, 32'h0, 4);
    wait_done("hold", 1'b0, stall_ok);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("hold_state", dbg_state, ST_DONE);
      check("hold_no_req", bus.mreq_valid, 1'b0);
      check("hold_wb_wdata", wb_wdata, 32'h1234_5678);
      check("hold_stallreq", stallreq, 1'b0);
    end
    stall_hold = 1'b0;
    release_op();

    // rdy low in the middle of a store
    start_op(OP_SW, 32'h0000_0900, 32'h0102_0304, 4);
    for (int c = 0; c < 20 && exp_q.size() != 3; c++) @(negedge clk);
    check("rdy_first_byte", exp_q.size(), 3);
    rdy = 1'b0;
    #1;
    check("rdy0_no_valid", bus.mreq_valid, 1'b0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check("rdy0_state", dbg_state, ST_ISSUE);
      check("rdy0_frozen", exp_q.size(), 3);
    end
    rdy = 1'b1;
    wait_done("rdy", 1'b0, stall_ok);
    check("rdy_wb_wreg", wb_wreg, 1'b0);
    check("rdy_reqs_missing", exp_q.size(), 0);
    release_op();

    // reset after two of four load bytes
    set_mem(32'h0000_0800, 32'h5566_7788);
    start_op(OP_LW, 32'h0000_0800, 32'h0, 4);
    for (int c = 0; c < 20 && exp_q.size() != 2; c++) @(negedge clk);
    check("rst_mid_two_issued", exp_q.size(), 2);
    rst = 1'b1;
    #1;
    check("rst_mid_stallreq", stallreq, 1'b0);
    check("rst_mid_no_req", bus.mreq_valid, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    mac_aluop = OP_ADD;
    mac_wdata = 32'h2468_ACE0;
    #1;
    check("rst_mid_state", dbg_state, ST_IDLE);
    check("rst_mid_no_more_reqs", exp_q.size(), 2);
    exp_q.delete();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("rst_late_state", dbg_state, ST_IDLE);
      check("rst_late_stallreq", stallreq, 1'b0);
      check("rst_late_add_wdata", wb_wdata, 32'h2468_ACE0);
      check("rst_late_add_wreg", wb_wreg, 1'b1);
    end
    mac_wdata = 32'hCAFE_0001;

    start_op(OP_LBU, 32'h0000_0400, 32'h0, 1);
    wait_done("post_rst", 1'b0, stall_ok);
    check("post_rst_wb_wdata", wb_wdata, 32'h0000_0080);
    release_op();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
